frg1_resp_misr: RTL and testbench
=================================

Name: frg1_resp_misr

Overview:
- Response-compaction stage directly downstream of the frg1 combinational benchmark.
- Accepts one 3-bit response vector (d0,e0,f0) per handshake and folds it into a multiple-input signature register (MISR).
- Counts accepted vectors and reports the final signature after a programmed vector count.
- Used by the benchmark equivalence harness to compare synthesized netlists against golden signatures without storing full response traces.

Parameters:
- RESP_W, 3, response vector width (frg1 outputs d0,e0,f0; bit0=d0, bit1=e0, bit2=f0).
- SIG_W, 16, signature width; must satisfy SIG_W > RESP_W.
- POLY, 16'h1021, MISR feedback polynomial, SIG_W bits.
- CNT_W, 16, width of vector count and counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request to begin a compaction run.
- num_vec  in  CNT_W  vectors to compact; sampled on accepted start.
- sig_seed  in  SIG_W  initial signature; sampled on accepted start.
- in_valid  in  1  response vector present on resp.
- in_ready  out  1  stage can accept a response.
- resp  in  RESP_W  response vector from frg1.
- busy  out  1  run in progress.
- sig_valid  out  1  final signature available.
- sig_out  out  SIG_W  current or final signature.
- vec_count  out  CNT_W  vectors accepted in the current run.

Behaviour:
- Interface: single clock clk; rst is asynchronous and active-high and forces all state to reset values immediately.
- Reset values: state=IDLE, sig_out=0, vec_count=0, in_ready=0, busy=0, sig_valid=0.
- FSM states are IDLE, RUN and DONE; all outputs are registered or decoded from state.
- IDLE:
  - in_ready=0.
  - start=1 loads sig<=sig_seed, vec_count<=0 and latches num_vec.
  - Next state is RUN if num_vec!=0, else DONE.
- RUN:
  - in_ready=1, busy=1.
  - Accept occurs when in_valid&&in_ready.
  - On accept: sig <= (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_extend(resp); vec_count<=vec_count+1.
  - The accept on which vec_count+1 == latched num_vec moves to DONE.
  - start in RUN is ignored.
  - in_valid without an accept leaves sig and vec_count unchanged.
- DONE:
  - sig_valid=1, busy=0, in_ready=0.
  - sig_out and vec_count hold.
  - start=1 re-seeds and behaves exactly as start from IDLE (back-to-back runs, no idle cycle required).
- Latency: the signature update is visible on sig_out the cycle after the accept. sig_valid asserts the cycle after the final accept.
- Throughput: one vector per cycle.
- num_vec=0: DONE the cycle after start, with sig_out=sig_seed and vec_count=0.
- vec_count never wraps, because the run terminates at num_vec ≤ 2^CNT_W-1.
- resp bits that are X are not masked; the bench must not drive X when in_valid=1.
- Reset mid-RUN aborts the run; no partial signature is retained.

Optional Feature:
- Macro: FRG1_MISR_GOLDEN_CMP_EN.
- When defined, the block adds:
  - input golden_sig[SIG_W];
  - outputs pass and fail, both reset to 0.
- golden_sig is sampled on the final accept. On entry to DONE, pass=(final sig==golden_sig) and fail=~pass; both hold until the next start or rst.
- When undefined, the ports are absent and there is no compare logic.

Decomposition:
- Shared package frg1_harness_pkg holds:
  - localparams RESP_W, SIG_W, CNT_W and default POLY;
  - typedef resp_t (RESP_W bits), sig_t (SIG_W bits), cnt_t (CNT_W bits);
  - enum misr_state_t {IDLE, RUN, DONE}.
- One natural sub-module, misr_step: a purely combinational next-signature function of (sig, resp, POLY), reused by the golden-signature generator model.

Test Plan:
1. rst asserted mid-cycle during RUN -> all outputs 0 and state IDLE immediately, without waiting for a clk edge.
2. seed=16'h0000, num_vec=1, resp=3'b101 accepted -> next cycle sig_out=16'h0005, vec_count=1, sig_valid=1.
3. seed=16'h0000, num_vec=2, resp=3'b101 then 3'b011 -> final sig_out=16'h0009.
4. seed=16'h8000, num_vec=1, resp=3'b000 -> sig_out=16'h1021, exercising the feedback path.
5. num_vec=0, seed=16'hBEEF -> DONE one cycle after start, sig_out=16'hBEEF, in_ready never asserted.
6. in_valid toggled randomly across 1000 vectors, start pulsed during RUN -> start ignored, vec_count=1000, signature matches a misr_step reference model; with FRG1_MISR_GOLDEN_CMP_EN and a correct golden_sig, pass=1, and with golden_sig^1, fail=1.

Source files
------------

// File: rtl/frg1_harness_pkg.sv
// Shared types and default parameters for the frg1 benchmark response harness.
package frg1_harness_pkg;
  localparam int RESP_W = 3;
  localparam int SIG_W  = 16;
  localparam int CNT_W  = 16;
  localparam logic [SIG_W-1:0] POLY = 16'h1021;

  typedef logic [RESP_W-1:0] resp_t;
  typedef logic [SIG_W-1:0]  sig_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } misr_state_t;
endpackage

// File: rtl/frg1_resp_misr_step.sv
// misr_step: combinational next-signature of the MISR (shift, polynomial feedback,
// response folded into the low bits).
module misr_step #(
  parameter int               SIG_W  = 16,
  parameter int               RESP_W = 3,
  parameter logic [SIG_W-1:0] POLY   = 16'h1021
) (
  input  logic [SIG_W-1:0]  sig,
  input  logic [RESP_W-1:0] resp,
  output logic [SIG_W-1:0]  sig_nxt
);
  always_comb begin
    sig_nxt = {sig[SIG_W-2:0], 1'b0}
            ^ (sig[SIG_W-1] ? POLY : {SIG_W{1'b0}})
            ^ {{(SIG_W-RESP_W){1'b0}}, resp};
  end
endmodule

// File: rtl/frg1_resp_misr.sv
// frg1_resp_misr: folds frg1 response vectors into a MISR and reports the final signature.
// Optional golden compare (pass/fail outputs) when FRG1_MISR_GOLDEN_CMP_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, no run loaded
// RUN   | accepting response vectors until num_vec have been folded
// DONE  | final signature held on sig_out, sig_valid high
module frg1_resp_misr
  import frg1_harness_pkg::*;
#(
  parameter int               RESP_W = frg1_harness_pkg::RESP_W,
  parameter int               SIG_W  = frg1_harness_pkg::SIG_W,
  parameter int               CNT_W  = frg1_harness_pkg::CNT_W,
  parameter logic [SIG_W-1:0] POLY   = frg1_harness_pkg::POLY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic [SIG_W-1:0]  sig_seed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              sig_valid,
  output logic [SIG_W-1:0]  sig_out,
  output logic [CNT_W-1:0]  vec_count
`ifdef FRG1_MISR_GOLDEN_CMP_EN
  ,
  input  logic [SIG_W-1:0]  golden_sig,
  output logic              pass,
  output logic              fail
`endif
);
  misr_state_t      state, state_nxt;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [SIG_W-1:0] sig_nxt;
  logic             start_acc, acc, last_acc;

  misr_step #(.SIG_W(SIG_W), .RESP_W(RESP_W), .POLY(POLY)) u_step (
    .sig     (sig_out),
    .resp    (resp),
    .sig_nxt (sig_nxt)
  );

  // start is only honoured outside RUN, so a stray pulse cannot corrupt a run
  assign start_acc = start && (state != RUN);
  assign acc       = in_valid && (state == RUN);
  assign cnt_inc   = vec_count + CNT_W'(1);
  assign last_acc  = acc && (cnt_inc == num_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (num_vec != '0) ? RUN : DONE;
      RUN:        if (last_acc) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    sig_valid = 1'b0;
    case (state)
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE:    sig_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_out   <= '0;
      vec_count <= '0;
      num_q     <= '0;
    end else if (start_acc) begin
      sig_out   <= sig_seed;
      vec_count <= '0;
      num_q     <= num_vec;
    end else if (acc) begin
      sig_out   <= sig_nxt;
      vec_count <= cnt_inc;
    end
  end

`ifdef FRG1_MISR_GOLDEN_CMP_EN
  // An empty run compares the seed itself, since it becomes the final signature
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass <= 1'b0;
      fail <= 1'b0;
    end else if (start_acc) begin
      pass <= (num_vec == '0) && (sig_seed == golden_sig);
      fail <= (num_vec == '0) && (sig_seed != golden_sig);
    end else if (last_acc) begin
      pass <= (sig_nxt == golden_sig);
      fail <= (sig_nxt != golden_sig);
    end
  end
`endif
endmodule

// File: tb/tb_frg1_resp_misr.sv
// Directed bench for frg1_resp_misr; also exercises golden compare when
// FRG1_MISR_GOLDEN_CMP_EN is defined.
module tb_frg1_resp_misr;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_vec;
  logic [15:0] sig_seed;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  resp;
  logic        busy;
  logic        sig_valid;
  logic [15:0] sig_out;
  logic [15:0] vec_count;
`ifdef FRG1_MISR_GOLDEN_CMP_EN
  logic [15:0] golden_sig;
  logic        pass;
  logic        fail;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] resp_mem [1000];

  always #5 clk = ~clk;

  frg1_resp_misr dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_vec   (num_vec),
    .sig_seed  (sig_seed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .resp      (resp),
    .busy      (busy),
    .sig_valid (sig_valid),
    .sig_out   (sig_out),
`ifdef FRG1_MISR_GOLDEN_CMP_EN
    .golden_sig(golden_sig),
    .pass      (pass),
    .fail      (fail),
`endif
    .vec_count (vec_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] seed, input logic [15:0] n);
    start    = 1'b1;
    sig_seed = seed;
    num_vec  = n;
    step();
    start    = 1'b0;
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [2:0] r);
    logic [15:0] n;
    n = s << 1;
    if (s[15]) n = n ^ 16'h1021;
    n = n ^ {13'b0, r};
    return n;
  endfunction

  task automatic run_1000(input logic [15:0] seed, input logic [15:0] gold_xor);
    logic [15:0] exp_sig;
    int idx, cyc;
    exp_sig = seed;
    for (int i = 0; i < 1000; i++) exp_sig = ref_step(exp_sig, resp_mem[i]);
`ifdef FRG1_MISR_GOLDEN_CMP_EN
    golden_sig = exp_sig ^ gold_xor;
`endif
    do_start(seed, 16'd1000);
    chk("run_busy", 32'(busy), 32'd1);
    idx = 0;
    cyc = 0;
    while (idx < 1000 && cyc < 6000) begin
      in_valid = 1'($urandom);
      resp     = in_valid ? resp_mem[idx] : 3'($urandom);
      start    = ($urandom_range(0, 15) == 0);
      sig_seed = 16'hDEAD;
      num_vec  = 16'd3;
      if (in_valid && in_ready) idx++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("run_vec_count", 32'(vec_count), 32'd1000);
    chk("run_sig", 32'(sig_out), 32'(exp_sig));
    chk("run_sig_valid", 32'(sig_valid), 32'd1);
    chk("run_busy_done", 32'(busy), 32'd0);
`ifdef FRG1_MISR_GOLDEN_CMP_EN
    chk("run_pass", 32'(pass), (gold_xor == 16'h0) ? 32'd1 : 32'd0);
    chk("run_fail", 32'(fail), (gold_xor == 16'h0) ? 32'd0 : 32'd1);
`endif
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    num_vec  = '0;
    sig_seed = '0;
    in_valid = 1'b0;
    resp     = '0;
`ifdef FRG1_MISR_GOLDEN_CMP_EN
    golden_sig = '0;
`endif
    for (int i = 0; i < 1000; i++) resp_mem[i] = 3'($urandom);

    #12;
    chk("rst_sig_out", 32'(sig_out), 32'd0);
    chk("rst_vec_count", 32'(vec_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sig_valid", 32'(sig_valid), 32'd0);
    rst = 1'b0;
    step();

    // single vector from zero seed
    do_start(16'h0000, 16'd1);
    chk("t2_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    resp     = 3'b101;
    step();
    in_valid = 1'b0;
    chk("t2_sig", 32'(sig_out), 32'h0005);
    chk("t2_vec_count", 32'(vec_count), 32'd1);
    chk("t2_sig_valid", 32'(sig_valid), 32'd1);
    chk("t2_in_ready", 32'(in_ready), 32'd0);

    // back-to-back run from DONE, two vectors
    do_start(16'h0000, 16'd2);
    in_valid = 1'b1;
    resp     = 3'b101;
    step();
    chk("t3_mid_sig", 32'(sig_out), 32'h0005);
    chk("t3_mid_valid", 32'(sig_valid), 32'd0);
    resp = 3'b011;
    step();
    in_valid = 1'b0;
    chk("t3_sig", 32'(sig_out), 32'h0009);
    chk("t3_vec_count", 32'(vec_count), 32'd2);
    // DONE holds even with in_valid asserted
    in_valid = 1'b1;
    resp     = 3'b111;
    step();
    step();
    in_valid = 1'b0;
    chk("t3_hold_sig", 32'(sig_out), 32'h0009);
    chk("t3_hold_cnt", 32'(vec_count), 32'd2);

    // feedback path
    do_start(16'h8000, 16'd1);
    in_valid = 1'b1;
    resp     = 3'b000;
    step();
    in_valid = 1'b0;
    chk("t4_sig", 32'(sig_out), 32'h1021);

    // empty run
`ifdef FRG1_MISR_GOLDEN_CMP_EN
    golden_sig = 16'hBEEF;
`endif
    do_start(16'hBEEF, 16'd0);
    chk("t5_sig_valid", 32'(sig_valid), 32'd1);
    chk("t5_sig", 32'(sig_out), 32'hBEEF);
    chk("t5_vec_count", 32'(vec_count), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
`ifdef FRG1_MISR_GOLDEN_CMP_EN
    chk("t5_pass", 32'(pass), 32'd1);
`endif

    run_1000(16'h1ACE, 16'h0000);
`ifdef FRG1_MISR_GOLDEN_CMP_EN
    run_1000(16'h1ACE, 16'h0001);
`endif

    // asynchronous reset in the middle of a run
    do_start(16'h1234, 16'd5);
    in_valid = 1'b1;
    resp     = 3'b010;
    step();
    in_valid = 1'b0;
    chk("t1_pre_sig", 32'(sig_out), 32'h246A);
    #2;
    rst = 1'b1;
    #1;
    chk("t1_sig_out", 32'(sig_out), 32'd0);
    chk("t1_vec_count", 32'(vec_count), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_in_ready", 32'(in_ready), 32'd0);
    chk("t1_sig_valid", 32'(sig_valid), 32'd0);
    #3;
    rst = 1'b0;
    step();
    chk("t1_idle_ready", 32'(in_ready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
